agc_timepulse_gen: RTL and testbench

Master timing-pulse generator for the AGC logic model. It divides the simulation clock into two non-overlapping phase clocks, `ph1` and `ph2`, and a one-hot 12-stage timepulse ring, T01 through T12. Together these form one memory cycle time (MCT). The block sits directly upstream of the 74HC-series gate parts and drives the phase and timepulse nets their NOR trees consume. It also provides monitor-style stop and single-step control.

---
 rtl/agc_timepulse_gen_if.sv | 31 +++
 rtl/agc_timepulse_gen.sv | 115 +++++++++++
 tb/tb_agc_timepulse_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_timepulse_gen_if.sv
// Control and timing-net bundle for agc_timepulse_gen.
// The master side (monitor/controller) issues stop/step requests and, when
// TPG_GOJAM_EN is defined, the gojam restart; the slave side is the generator.
interface agc_timepulse_gen_if;
    logic        stop_req;
    logic        step;
`ifdef TPG_GOJAM_EN
    logic        gojam;
`endif
    logic        ph1;
    logic        ph2;
    logic [11:0] t;
    logic        mct_end;
    logic        stopped;

    modport master (
        input  ph1, ph2, t, mct_end, stopped,
`ifdef TPG_GOJAM_EN
        output gojam,
`endif
        output stop_req, step
    );

    modport slave (
        output ph1, ph2, t, mct_end, stopped,
`ifdef TPG_GOJAM_EN
        input  gojam,
`endif
        input  stop_req, step
    );
endinterface

// File: rtl/agc_timepulse_gen.sv
// AGC master timing-pulse generator: two non-overlapping phase clocks and a
// one-hot 12-stage timepulse ring (T01..T12) forming one memory cycle time.
// Optional feature macro: TPG_GOJAM_EN adds the synchronous gojam restart.
//
// state   | meaning
// --------+------------------------------------------------------------
// START   | just out of reset, enters RUN on the first clk
// RUN     | free running, may halt at an MCT boundary on stop_req
// STOPPED | halted at T01/sc=0/pre=0, waits for resume or a step edge
// STEP    | runs exactly one MCT, then halts or runs on per stop_req
module agc_timepulse_gen #(
    parameter int unsigned DIV = 2
) (
    input logic               clk,
    input logic               rst,
    agc_timepulse_gen_if.slave bus
);
    typedef enum logic [1:0] {START, RUN, STOPPED, STEP} state_t;

    localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

    state_t      fsm, fsm_n;
    logic [7:0]  pre, pre_n;
    logic [1:0]  sc, sc_n;
    logic [11:0] t_q, t_n;
    logic        step_d;
    logic        ph1_q, ph2_q, mct_end_q, stopped_q;
    logic        active, active_n, wrap, tick, boundary, step_rise;
    logic        gojam;

`ifdef TPG_GOJAM_EN
    assign gojam = bus.gojam;
`else
    assign gojam = 1'b0;
`endif

    // Next-state decode for prescaler, sub-phase, ring and sequencing FSM.
    always_comb begin
        active    = (fsm == RUN) || (fsm == STEP);
        wrap      = (pre == PRE_LAST);
        tick      = active && wrap && (sc == 2'd3);
        boundary  = tick && t_q[11];
        step_rise = bus.step && !step_d;

        fsm_n = fsm;
        pre_n = pre;
        sc_n  = sc;
        t_n   = t_q;

        if (active) begin
            if (wrap) begin
                pre_n = 8'd0;
                sc_n  = sc + 2'd1;
            end else begin
                pre_n = pre + 8'd1;
            end
        end
        if (tick) begin
            t_n = {t_q[10:0], t_q[11]};
        end

        case (fsm)
            START:   fsm_n = RUN;
            RUN:     if (boundary && bus.stop_req) fsm_n = STOPPED;
            STOPPED: begin
                if (!bus.stop_req)  fsm_n = RUN;
                else if (step_rise) fsm_n = STEP;
            end
            STEP:    if (boundary) fsm_n = bus.stop_req ? STOPPED : RUN;
            default: fsm_n = START;
        endcase

        // Restart wins over tick and stop handling; a halted generator stays halted.
        if (gojam) begin
            pre_n = 8'd0;
            sc_n  = 2'd0;
            t_n   = 12'h001;
            if (fsm != STOPPED) fsm_n = RUN;
        end

        active_n = (fsm_n == RUN) || (fsm_n == STEP);
    end

    // State and output registers; outputs are decodes of the next state so
    // they line up with the state they describe and carry no input path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= START;
            pre       <= 8'd0;
            sc        <= 2'd0;
            t_q       <= 12'h001;
            step_d    <= 1'b0;
            ph1_q     <= 1'b0;
            ph2_q     <= 1'b0;
            mct_end_q <= 1'b0;
            stopped_q <= 1'b0;
        end else begin
            fsm       <= fsm_n;
            pre       <= pre_n;
            sc        <= sc_n;
            t_q       <= t_n;
            step_d    <= bus.step;
            ph1_q     <= active_n && (sc_n == 2'd0);
            ph2_q     <= active_n && (sc_n == 2'd2);
            mct_end_q <= active_n && (sc_n == 2'd3) && (pre_n == PRE_LAST) && t_n[11];
            stopped_q <= (fsm_n == STOPPED);
        end
    end

    assign bus.ph1     = ph1_q;
    assign bus.ph2     = ph2_q;
    assign bus.t       = t_q;
    assign bus.mct_end = mct_end_q;
    assign bus.stopped = stopped_q;
endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Scoreboard bench for agc_timepulse_gen: a cycle-position model predicts
// every clk's outputs, a monitor compares them against the DUT.
module tb_agc_timepulse_gen;
    localparam int DIV  = 2;
    localparam int LAST = 48 * DIV - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    agc_timepulse_gen_if bus();

    agc_timepulse_gen #(.DIV(DIV)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ph1;
        logic        ph2;
        logic [11:0] t;
        logic        mct_end;
        logic        stopped;
    } obs_t;

    typedef enum int {M_START, M_RUN, M_STOP, M_STEP} mode_t;

    obs_t  expq[$];
    int    vectors = 0;
    int    miscompares = 0;
    mode_t mode = M_START;
    int    k = 0;
    logic  step_prev = 1'b0;

    // Expected outputs from the clk position k within the MCT.
    function automatic obs_t predict(input mode_t m, input int kk);
        obs_t e;
        bit   act;
        int   sub;
        act       = (m == M_RUN) || (m == M_STEP);
        sub       = (kk / DIV) % 4;
        e.t       = act ? (12'h001 << (kk / (4 * DIV))) : 12'h001;
        e.ph1     = act && (sub == 0);
        e.ph2     = act && (sub == 2);
        e.mct_end = act && (kk == LAST);
        e.stopped = (m == M_STOP);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.ph1     = bus.ph1;
        o.ph2     = bus.ph2;
        o.t       = bus.t;
        o.mct_end = bus.mct_end;
        o.stopped = bus.stopped;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t: event not seen within cycle budget", nm, $time);
    endtask

    // Reference model: advance the MCT position and mode on each clk edge.
    always @(posedge clk or negedge rst) begin : model
        mode_t m;
        int    kk;
        logic  rise;
        if (!rst) begin
            mode      <= M_START;
            k         <= 0;
            step_prev <= 1'b0;
            expq.delete();
        end else begin
            m    = mode;
            kk   = k;
            rise = bus.step && !step_prev;
            case (m)
                M_START: begin m = M_RUN; kk = 0; end
                M_RUN: begin
                    if (kk == LAST) begin
                        kk = 0;
                        if (bus.stop_req) m = M_STOP;
                    end else kk++;
                end
                M_STOP: begin
                    kk = 0;
                    if (!bus.stop_req) m = M_RUN;
                    else if (rise)     m = M_STEP;
                end
                default: begin
                    if (kk == LAST) begin
                        kk = 0;
                        m  = bus.stop_req ? M_STOP : M_RUN;
                    end else kk++;
                end
            endcase
`ifdef TPG_GOJAM_EN
            if (bus.gojam) begin
                kk = 0;
                if (mode != M_STOP) m = M_RUN;
            end
`endif
            mode      <= m;
            k         <= kk;
            step_prev <= bus.step;
            expq.push_back(predict(m, kk));
        end
    end

    // Monitor: compare the DUT against the oldest prediction each clk.
    always @(posedge clk) begin : monitor
        obs_t e;
        #1;
        if (rst && expq.size() > 0) begin
            e = expq.pop_front();
            chk("scoreboard", 32'(observe()), 32'(e));
        end
    end

    task automatic wait_t(input int idx, input int budget, input string nm);
        int n;
        n = 0;
        while (!bus.t[idx] && n < budget) begin @(negedge clk); n++; end
        if (!bus.t[idx]) timeout(nm);
    endtask

    task automatic wait_stopped(input int budget, input string nm);
        int n;
        n = 0;
        while (!bus.stopped && n < budget) begin @(negedge clk); n++; end
        if (!bus.stopped) timeout(nm);
    endtask

    localparam logic [15:0] RESET_OBS = {1'b0, 1'b0, 12'h001, 1'b0, 1'b0};

    initial begin
        bus.stop_req = 1'b0;
        bus.step     = 1'b0;
`ifdef TPG_GOJAM_EN
        bus.gojam    = 1'b0;
`endif
        // Reset held for 5 clks
        repeat (5) @(negedge clk);
        chk("reset_hold", 32'(observe()), 32'(RESET_OBS));
        rst = 1'b1;

        // Free run with random step noise (ignored while running)
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.step = ($urandom_range(0, 3) == 0);
        end
        bus.step = 1'b0;

        // Stop requested during T05, hold halted for 300 clks
        wait_t(4, 200, "wait_t05");
        bus.stop_req = 1'b1;
        wait_stopped(100, "stop_latency");
        repeat (300) @(negedge clk);
        chk("stop_hold", 32'(observe()), 32'({1'b0, 1'b0, 12'h001, 1'b0, 1'b1}));

        // Single step with a second edge mid-MCT
        bus.step = 1'b1;
        repeat (3) @(negedge clk);
        bus.step = 1'b0;
        repeat (40) @(negedge clk);
        bus.step = 1'b1;
        repeat (2) @(negedge clk);
        bus.step = 1'b0;
        wait_stopped(120, "step_end");
        repeat (50) @(negedge clk);
        chk("step_not_queued", 32'(bus.stopped), 32'd1);

        // Resume: RUN entered on the next edge with ph1 high
        bus.stop_req = 1'b0;
        @(negedge clk);
        chk("resume_ph1", 32'(bus.ph1), 32'd1);

        // Randomized stop/step traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) bus.stop_req = !bus.stop_req;
            bus.step = ($urandom_range(0, 7) == 0);
`ifdef TPG_GOJAM_EN
            bus.gojam = ($urandom_range(0, 199) == 0);
`endif
        end
        bus.step     = 1'b0;
        bus.stop_req = 1'b0;
`ifdef TPG_GOJAM_EN
        bus.gojam    = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-T07, between clk edges
        wait_t(6, 200, "wait_t07");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", 32'(observe()), 32'(RESET_OBS));
        @(negedge clk);
        chk("reset_held", 32'(observe()), 32'(RESET_OBS));
        rst = 1'b1;
        @(negedge clk);
        chk("reset_release_ph1", 32'(bus.ph1), 32'd1);

`ifdef TPG_GOJAM_EN
        // gojam during T09 sc=2 restarts at T01
        begin
            int n;
            n = 0;
            while (!(bus.t[8] && bus.ph2) && n < 200) begin @(negedge clk); n++; end
            if (!(bus.t[8] && bus.ph2)) timeout("wait_t09_ph2");
        end
        bus.gojam = 1'b1;
        @(negedge clk);
        bus.gojam = 1'b0;
        chk("gojam_t", 32'(bus.t), 32'h001);
        chk("gojam_ph1", 32'(bus.ph1), 32'd1);
        repeat (8) @(negedge clk);
        chk("gojam_t02", 32'(bus.t), 32'h002);
`endif

        repeat (200) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
